// File: rtl/fpu_wb_regs.sv
`default_nettype none
// ============================================================================
// Module   : fpu_wb_regs
// Purpose  : Wishbone slave register block fronting an FPU core. Holds the
//            operand, control and status registers, issues a one-cycle start
//            pulse, captures result/flags/latency, aborts hung operations
//            with a watchdog and drives a registered level interrupt.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   s_stb_i/s_we_i/s_adr_i   Wishbone request (strobe held until ack)
//   s_dat_i                  Wishbone write data
//   s_dat_o/s_ack_o          registered read data and single-cycle ack
//   fpu_start                one-cycle operation start
//   fpu_op/fpu_rmode         operation code and rounding mode (CTRL)
//   fpu_a/fpu_b              operands (OPA/OPB)
//   fpu_done/fpu_result/
//   fpu_flags                core completion pulse with result and flags
//   irq                      level interrupt (done & irq_en, registered)
// ============================================================================
module fpu_wb_regs #(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int          TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_stb_i,
   input  logic        s_we_i,
   input  logic [31:0] s_adr_i,
   input  logic [31:0] s_dat_i,
   output logic [31:0] s_dat_o,
   output logic        s_ack_o,
   output logic        fpu_start,
   output logic [2:0]  fpu_op,
   output logic [1:0]  fpu_rmode,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   input  logic        fpu_done,
   input  logic [31:0] fpu_result,
   input  logic [4:0]  fpu_flags,
   output logic        irq
);

   localparam logic [0:0]  c_st_idle  = 1'b0;
   localparam logic [0:0]  c_st_busy  = 1'b1;

   localparam logic [2:0]  c_sel_opa  = 3'd0;
   localparam logic [2:0]  c_sel_opb  = 3'd1;
   localparam logic [2:0]  c_sel_ctrl = 3'd2;
   localparam logic [2:0]  c_sel_stat = 3'd3;
   localparam logic [2:0]  c_sel_res  = 3'd4;
   localparam logic [2:0]  c_sel_cyc  = 3'd5;

   localparam logic [16:0] c_timeout  = 17'(TIMEOUT);

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [0:0]  r_state;
   logic        r_ack;
   logic [31:0] r_dat;
   logic        r_start;
   logic        r_irq;
   logic [31:0] r_opa;
   logic [31:0] r_opb;
   logic [2:0]  r_op;
   logic [1:0]  r_rmode;
   logic        r_irq_en;
   logic        r_done;
   logic        r_err;
   logic        r_timeout;
   logic [4:0]  r_flags;
   logic [31:0] r_result;
   logic [15:0] r_cnt;
   logic [15:0] r_cycles;

   // -------------------------------------------------------------------------
   // Bus decode
   // -------------------------------------------------------------------------
   logic        w_busy;
   logic        w_commit;
   logic        w_hit;
   logic [2:0]  w_sel;
   logic        w_wr;
   logic        w_rd;
   logic        w_wr_opa;
   logic        w_wr_opb;
   logic        w_wr_ctrl;
   logic        w_wr_stat;
   logic        w_cfg_wr;
   logic        w_cfg_ok;
   logic        w_err_set;
   logic        w_go;
   logic [16:0] w_cnt_inc;
   logic        w_fin_done;
   logic        w_fin_to;
   logic        w_w1c_done;
   logic        w_w1c_err;
   logic        w_w1c_to;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_busy    = (r_state == c_st_busy);

   // An access commits on the edge that raises ack; the cycle while ack is
   // high never commits, so a held strobe is served every other cycle.
   assign w_commit  = s_stb_i & ~r_ack;
   assign w_hit     = (s_adr_i[31:8] == ADDR_BASE[31:8]);
   assign w_sel     = s_adr_i[4:2];
   assign w_wr      = w_commit & s_we_i & w_hit;
   assign w_rd      = w_commit & ~s_we_i & w_hit;

   assign w_wr_opa  = w_wr & (w_sel == c_sel_opa);
   assign w_wr_opb  = w_wr & (w_sel == c_sel_opb);
   assign w_wr_ctrl = w_wr & (w_sel == c_sel_ctrl);
   assign w_wr_stat = w_wr & (w_sel == c_sel_stat);

   // Configuration must not change under a running operation: such writes
   // are discarded and flagged instead.
   assign w_cfg_wr  = w_wr_opa | w_wr_opb | w_wr_ctrl;
   assign w_cfg_ok  = w_cfg_wr & ~w_busy;
   assign w_err_set = w_cfg_wr & w_busy;
   assign w_go      = w_wr_ctrl & ~w_busy & s_dat_i[31];

   // Extra bit keeps the compare against TIMEOUT exact at the top of range.
   assign w_cnt_inc  = {1'b0, r_cnt} + 17'd1;
   // Completion takes priority over the watchdog in the same cycle.
   assign w_fin_done = w_busy & fpu_done;
   assign w_fin_to   = w_busy & ~fpu_done & (w_cnt_inc == c_timeout);

   assign w_w1c_done = w_wr_stat & s_dat_i[1];
   assign w_w1c_err  = w_wr_stat & s_dat_i[7];
   assign w_w1c_to   = w_wr_stat & s_dat_i[8];

   // Address bits outside the compare and the word select are don't-care.
   assign w_unused   = &{1'b0, s_adr_i[7:5], s_adr_i[1:0]};

   always_comb begin
      w_rdata = 32'h0;
      case (w_sel)
         c_sel_opa:  w_rdata = r_opa;
         c_sel_opb:  w_rdata = r_opb;
         c_sel_ctrl: w_rdata = {23'h0, r_irq_en, 3'h0, r_rmode, r_op};
         c_sel_stat: w_rdata = {23'h0, r_timeout, r_err, r_flags, r_done, w_busy};
         c_sel_res:  w_rdata = r_result;
         c_sel_cyc:  w_rdata = {16'h0, r_cycles};
         default:    w_rdata = 32'h0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Bus response: read data is forced to zero outside the ack cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack <= 1'b0;
         r_dat <= 32'h0;
      end else begin
         r_ack <= w_commit;
         r_dat <= w_rd ? w_rdata : 32'h0;
      end
   end

   // -------------------------------------------------------------------------
   // Configuration registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_opa    <= 32'h0;
         r_opb    <= 32'h0;
         r_op     <= 3'h0;
         r_rmode  <= 2'h0;
         r_irq_en <= 1'b0;
      end else if (w_cfg_ok) begin
         if (w_wr_opa) begin
            r_opa <= s_dat_i;
         end
         if (w_wr_opb) begin
            r_opb <= s_dat_i;
         end
         if (w_wr_ctrl) begin
            r_op     <= s_dat_i[2:0];
            r_rmode  <= s_dat_i[4:3];
            r_irq_en <= s_dat_i[8];
         end
      end
   end

   // -------------------------------------------------------------------------
   // Operation sequencing, status and capture
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_st_idle;
         r_start   <= 1'b0;
         r_cnt     <= 16'h0;
         r_cycles  <= 16'h0;
         r_result  <= 32'h0;
         r_flags   <= 5'h0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_start <= w_go;

         case (r_state)
            c_st_idle: begin
               if (w_go) begin
                  r_state <= c_st_busy;
                  r_cnt   <= 16'h0;
               end
            end
            c_st_busy: begin
               if (w_fin_done | w_fin_to) begin
                  r_state <= c_st_idle;
               end else if (r_cnt != 16'hFFFF) begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: r_state <= c_st_idle;
         endcase

         if (w_fin_done) begin
            r_result <= fpu_result;
            r_flags  <= fpu_flags;
            r_cycles <= (r_cnt == 16'hFFFF) ? 16'hFFFF : w_cnt_inc[15:0];
         end else if (w_fin_to) begin
            r_cycles <= c_timeout[15:0];
         end

         // A new event wins over a simultaneous write-one-to-clear.
         if (w_go) begin
            r_done <= 1'b0;
         end else if (w_fin_done | w_fin_to) begin
            r_done <= 1'b1;
         end else if (w_w1c_done) begin
            r_done <= 1'b0;
         end

         if (w_err_set) begin
            r_err <= 1'b1;
         end else if (w_w1c_err) begin
            r_err <= 1'b0;
         end

         if (w_go) begin
            r_timeout <= 1'b0;
         end else if (w_fin_to) begin
            r_timeout <= 1'b1;
         end else if (w_w1c_to) begin
            r_timeout <= 1'b0;
         end
      end
   end

   // Interrupt follows the registered done/irq_en by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= r_done & r_irq_en;
      end
   end

   assign s_ack_o   = r_ack;
   assign s_dat_o   = r_dat;
   assign fpu_start = r_start;
   assign fpu_op    = r_op;
   assign fpu_rmode = r_rmode;
   assign fpu_a     = r_opa;
   assign fpu_b     = r_opb;
   assign irq       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_fpu_wb_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_wb_regs
// Purpose  : Self-checking bench for fpu_wb_regs. A transaction-level model
//            of the register map and operation lifecycle predicts every read
//            and output; the FPU core is emulated by timed done pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_wb_regs;

   localparam logic [31:0] BASE = 32'hA000_0000;
   localparam int          TMO  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_stb_i = 1'b0;
   logic        s_we_i = 1'b0;
   logic [31:0] s_adr_i = 32'h0;
   logic [31:0] s_dat_i = 32'h0;
   logic [31:0] s_dat_o;
   logic        s_ack_o;
   logic        fpu_start;
   logic [2:0]  fpu_op;
   logic [1:0]  fpu_rmode;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic        fpu_done = 1'b0;
   logic [31:0] fpu_result = 32'h0;
   logic [4:0]  fpu_flags = 5'h0;
   logic        irq;

   always #5 clk = ~clk;

   fpu_wb_regs #(.ADDR_BASE(BASE), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_stb_i(s_stb_i), .s_we_i(s_we_i), .s_adr_i(s_adr_i), .s_dat_i(s_dat_i),
      .s_dat_o(s_dat_o), .s_ack_o(s_ack_o),
      .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
      .fpu_a(fpu_a), .fpu_b(fpu_b),
      .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
      .irq(irq)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;        // rising edges seen so far
   int start_cnt = 0;  // cycles in which fpu_start was high
   logic irq_at_ack;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (fpu_start === 1'b1) start_cnt <= start_cnt + 1;

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   logic [31:0] m_opa, m_opb, m_result;
   logic [2:0]  m_op;
   logic [1:0]  m_rmode;
   logic        m_irq_en, m_busy, m_done, m_err, m_to;
   logic [4:0]  m_flags;
   logic [15:0] m_cycles;
   int          go_cyc;   // edge on which the running operation was launched

   function automatic void model_reset();
      m_opa = 0; m_opb = 0; m_result = 0; m_op = 0; m_rmode = 0;
      m_irq_en = 0; m_busy = 0; m_done = 0; m_err = 0; m_to = 0;
      m_flags = 0; m_cycles = 0; go_cyc = 0;
   endfunction

   // An operation left running for TMO edges has been aborted.
   function automatic void model_sync();
      if (m_busy && (cyc - go_cyc) >= TMO) begin
         m_busy = 0; m_done = 1; m_to = 1; m_cycles = 16'(TMO);
      end
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] adr);
      if ((adr & 32'hFFFF_FF00) != BASE) return 32'h0;
      case ((adr % 32) / 4)
         0: return m_opa;
         1: return m_opb;
         2: return 32'(m_op) + 32'(m_rmode) * 8 + 32'(m_irq_en) * 256;
         3: return 32'(m_busy) + 32'(m_done) * 2 + 32'(m_flags) * 4
                   + 32'(m_err) * 128 + 32'(m_to) * 256;
         4: return m_result;
         5: return 32'(m_cycles);
         default: return 32'h0;
      endcase
   endfunction

   function automatic void model_write(input logic [31:0] adr, input logic [31:0] dat);
      int idx;
      if ((adr & 32'hFFFF_FF00) != BASE) return;
      idx = (adr % 32) / 4;
      if (idx <= 2 && m_busy) begin
         m_err = 1;
      end else if (idx == 0) begin
         m_opa = dat;
      end else if (idx == 1) begin
         m_opb = dat;
      end else if (idx == 2) begin
         m_op = dat[2:0]; m_rmode = dat[4:3]; m_irq_en = dat[8];
         if (dat[31]) begin
            m_busy = 1; m_done = 0; m_to = 0; go_cyc = cyc + 1;
         end
      end else if (idx == 3) begin
         if (dat[1]) m_done = 0;
         if (dat[7]) m_err = 0;
         if (dat[8]) m_to = 0;
      end
   endfunction

   // ------------------------------------------------------------------------
   // Bus and core drivers
   // ------------------------------------------------------------------------
   // ok=1 when ack came exactly one cycle after stb and dropped (with data
   // returning to 0) on the following cycle.
   task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            output logic [31:0] rd, output logic [31:0] ex, output logic ok);
      int lat;
      model_sync();
      ex = model_read(adr);
      if (we) model_write(adr, dat);
      s_stb_i = 1'b1; s_we_i = we; s_adr_i = adr; s_dat_i = dat;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (s_ack_o !== 1'b1 && lat < 8);
      rd = s_dat_o;
      irq_at_ack = irq;
      ok = (s_ack_o === 1'b1) && (lat == 1);
      s_stb_i = 1'b0; s_we_i = 1'b0; s_adr_i = 32'h0; s_dat_i = 32'h0;
      @(posedge clk); #1;
      ok = ok && (s_ack_o === 1'b0) && (s_dat_o === 32'h0);
   endtask

   task automatic pulse_done(input logic [31:0] res, input logic [4:0] flg);
      model_sync();
      if (m_busy) begin
         m_result = res; m_flags = flg; m_cycles = 16'(cyc + 1 - go_cyc);
         m_busy = 0; m_done = 1;
      end
      fpu_done = 1'b1; fpu_result = res; fpu_flags = flg;
      @(posedge clk); #1;
      fpu_done = 1'b0; fpu_result = $urandom; fpu_flags = 5'($urandom);
   endtask

   // Completes the operation so that it reports n busy cycles.
   task automatic fpu_finish(input int n, input logic [31:0] res, input logic [4:0] flg);
      while (cyc + 1 - go_cyc < n) begin
         @(posedge clk); #1;
      end
      pulse_done(res, flg);
   endtask

   // ------------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------------
   task automatic test_reset();
      logic [31:0] rd, ex; logic ok;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({s_ack_o, s_dat_o, fpu_start, irq, fpu_a, fpu_b, fpu_op, fpu_rmode} !== 104'h0) begin
         errors++;
         $display("FAIL reset_outputs got ack=%b dat=%h start=%b irq=%b a=%h b=%h op=%h rm=%h want all 0",
                  s_ack_o, s_dat_o, fpu_start, irq, fpu_a, fpu_b, fpu_op, fpu_rmode);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wb_access(1'b0, BASE + 32'(i * 4), 32'h0, rd, ex, ok);
         checks++;
         if (rd !== ex || ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_read[%0d] got %h ok=%b want %h ok=1", i, rd, ok, ex);
         end
      end
   endtask

   task automatic test_basic_op();
      logic [31:0] rd, ex; logic [2:0] oks; int s0;
      s0 = start_cnt;
      wb_access(1'b1, BASE + 32'h00, 32'h3F80_0000, rd, ex, oks[0]);
      wb_access(1'b1, BASE + 32'h04, 32'h4000_0000, rd, ex, oks[1]);
      wb_access(1'b1, BASE + 32'h08, 32'h8000_0101, rd, ex, oks[2]);
      checks++;
      if (oks !== 3'b111) begin
         errors++; $display("FAIL basic_ack got %b want 111", oks);
      end
      checks++;
      if ({fpu_a, fpu_b, fpu_op, fpu_rmode} !== {m_opa, m_opb, m_op, m_rmode}) begin
         errors++;
         $display("FAIL basic_operands got a=%h b=%h op=%h rm=%h want a=%h b=%h op=%h rm=%h",
                  fpu_a, fpu_b, fpu_op, fpu_rmode, m_opa, m_opb, m_op, m_rmode);
      end
      fpu_finish(4, 32'h4040_0000, 5'h01);
      checks++;
      if (start_cnt !== s0 + 1) begin
         errors++; $display("FAIL basic_start_pulses got %0d want 1", start_cnt - s0);
      end
      for (int i = 3; i < 6; i++) begin
         wb_access(1'b0, BASE + 32'(i * 4), 32'h0, rd, ex, oks[0]);
         checks++;
         if (rd !== ex || oks[0] !== 1'b1) begin
            errors++; $display("FAIL basic_read[%0d] got %h want %h", i, rd, ex);
         end
      end
      checks++;
      if (irq !== (m_done & m_irq_en)) begin
         errors++; $display("FAIL basic_irq got %b want %b", irq, m_done & m_irq_en);
      end
   endtask

   task automatic test_w1c_irq();
      logic [31:0] rd, ex; logic ok;
      wb_access(1'b1, BASE + 32'h0C, 32'h0000_0002, rd, ex, ok);
      checks++;
      if ({irq_at_ack, irq} !== 2'b10) begin
         errors++; $display("FAIL w1c_irq_timing got at_ack=%b after=%b want 1 then 0", irq_at_ack, irq);
      end
      wb_access(1'b0, BASE + 32'h0C, 32'h0, rd, ex, ok);
      checks++;
      if (rd !== ex || ok !== 1'b1) begin
         errors++; $display("FAIL w1c_status got %h want %h", rd, ex);
      end
   endtask

   task automatic test_busy_err();
      logic [31:0] rd, ex; logic [3:0] oks; int s0;
      s0 = start_cnt;
      wb_access(1'b1, BASE + 32'h08, 32'h8000_0012, rd, ex, oks[0]);
      wb_access(1'b1, BASE + 32'h08, 32'h8000_0105, rd, ex, oks[1]);
      wb_access(1'b1, BASE + 32'h00, $urandom, rd, ex, oks[2]);
      wb_access(1'b0, BASE + 32'h0C, 32'h0, rd, ex, oks[3]);
      checks++;
      if (rd !== ex || oks !== 4'hF) begin
         errors++; $display("FAIL busy_status got %h ok=%b want %h", rd, oks, ex);
      end
      checks++;
      if ({fpu_a, fpu_op, fpu_rmode} !== {m_opa, m_op, m_rmode}) begin
         errors++; $display("FAIL busy_dropped got a=%h op=%h rm=%h want a=%h op=%h rm=%h",
                            fpu_a, fpu_op, fpu_rmode, m_opa, m_op, m_rmode);
      end
      fpu_finish(10, $urandom, 5'($urandom));
      checks++;
      if (start_cnt !== s0 + 1) begin
         errors++; $display("FAIL busy_start_pulses got %0d want 1", start_cnt - s0);
      end
      for (int i = 2; i < 6; i++) begin
         wb_access(1'b0, BASE + 32'(i * 4), 32'h0, rd, ex, oks[0]);
         checks++;
         if (rd !== ex) begin
            errors++; $display("FAIL busy_read[%0d] got %h want %h", i, rd, ex);
         end
      end
      wb_access(1'b1, BASE + 32'h0C, 32'h0000_0080, rd, ex, oks[0]);
      wb_access(1'b0, BASE + 32'h0C, 32'h0, rd, ex, oks[0]);
      checks++;
      if (rd !== ex) begin
         errors++; $display("FAIL busy_err_clear got %h want %h", rd, ex);
      end
   endtask

   task automatic test_timeout();
      logic [31:0] rd, ex; logic ok; int s0;
      wb_access(1'b1, BASE + 32'h0C, 32'h0000_0182, rd, ex, ok);
      s0 = start_cnt;
      wb_access(1'b1, BASE + 32'h08, 32'h8000_0105, rd, ex, ok);
      repeat (6) @(posedge clk);
      #1;
      wb_access(1'b0, BASE + 32'h0C, 32'h0, rd, ex, ok);
      checks++;
      if (rd !== ex) begin
         errors++; $display("FAIL timeout_still_busy got %h want %h", rd, ex);
      end
      while (cyc - go_cyc < TMO + 2) begin
         @(posedge clk); #1;
      end
      wb_access(1'b0, BASE + 32'h0C, 32'h0, rd, ex, ok);
      checks++;
      if (rd !== ex) begin
         errors++; $display("FAIL timeout_status got %h want %h", rd, ex);
      end
      wb_access(1'b0, BASE + 32'h14, 32'h0, rd, ex, ok);
      checks++;
      if (rd !== ex) begin
         errors++; $display("FAIL timeout_cycles got %h want %h", rd, ex);
      end
      pulse_done(32'hDEAD_BEEF, 5'h1F);
      wb_access(1'b0, BASE + 32'h10, 32'h0, rd, ex, ok);
      checks++;
      if (rd !== ex) begin
         errors++; $display("FAIL late_done_result got %h want %h", rd, ex);
      end
      wb_access(1'b0, BASE + 32'h0C, 32'h0, rd, ex, ok);
      checks++;
      if (rd !== ex) begin
         errors++; $display("FAIL late_done_status got %h want %h", rd, ex);
      end
      checks++;
      if (start_cnt !== s0 + 1 || irq !== (m_done & m_irq_en)) begin
         errors++; $display("FAIL timeout_start_irq got starts=%0d irq=%b want 1 and %b",
                            start_cnt - s0, irq, m_done & m_irq_en);
      end
   endtask

   // Completion arriving on the last allowed cycle must beat the watchdog.
   task automatic test_done_at_limit();
      logic [31:0] rd, ex; logic ok;
      wb_access(1'b1, BASE + 32'h08, 32'h8000_001A, rd, ex, ok);
      fpu_finish(TMO, $urandom, 5'($urandom));
      for (int i = 3; i < 6; i++) begin
         wb_access(1'b0, BASE + 32'(i * 4), 32'h0, rd, ex, ok);
         checks++;
         if (rd !== ex) begin
            errors++; $display("FAIL limit_read[%0d] got %h want %h", i, rd, ex);
         end
      end
   endtask

   task automatic test_decode();
      logic [31:0] rd, ex; logic ok;
      logic [31:0] adrs [4];
      adrs[0] = BASE + 32'h100; adrs[1] = BASE + 32'h1C;
      adrs[2] = BASE + 32'h108; adrs[3] = BASE + 32'h18;
      for (int i = 0; i < 4; i++) begin
         wb_access(1'b0, adrs[i], 32'h0, rd, ex, ok);
         checks++;
         if (rd !== 32'h0 || ok !== 1'b1) begin
            errors++; $display("FAIL decode_read[%0d] got %h ok=%b want 0 ok=1", i, rd, ok);
         end
         wb_access(1'b1, adrs[i], 32'hFFFF_FFFF, rd, ex, ok);
         checks++;
         if (ok !== 1'b1) begin
            errors++; $display("FAIL decode_write_ack[%0d] got ok=%b want 1", i, ok);
         end
      end
      for (int i = 0; i < 6; i++) begin
         wb_access(1'b0, BASE + 32'(i * 4), 32'h0, rd, ex, ok);
         checks++;
         if (rd !== ex) begin
            errors++; $display("FAIL decode_regs[%0d] got %h want %h", i, rd, ex);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] acks;
      s_stb_i = 1'b1; s_we_i = 1'b0; s_adr_i = BASE;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         acks[3 - i] = s_ack_o;
      end
      s_stb_i = 1'b0; s_adr_i = 32'h0;
      @(posedge clk); #1;
      checks++;
      if (acks !== 4'b1010) begin
         errors++; $display("FAIL held_stb_acks got %b want 1010", acks);
      end
   endtask

   task automatic test_random_regs();
      logic [31:0] rd, ex, adr, dat; logic ok, we;
      for (int i = 0; i < 40; i++) begin
         we  = 1'($urandom);
         dat = $urandom & 32'h7FFF_FFFF;
         adr = BASE | (32'($urandom_range(0, 7)) * 4) | ($urandom & 32'hE3);
         if ($urandom_range(0, 7) == 0) adr = adr + 32'h100 * 32'($urandom_range(1, 3));
         wb_access(we, adr, dat, rd, ex, ok);
         checks++;
         if (ok !== 1'b1 || (!we && rd !== ex)) begin
            errors++; $display("FAIL rand_access[%0d] adr=%h we=%b got %h ok=%b want %h",
                               i, adr, we, rd, ok, ex);
         end
         checks++;
         if ({fpu_a, fpu_b, fpu_op, fpu_rmode} !== {m_opa, m_opb, m_op, m_rmode}) begin
            errors++; $display("FAIL rand_outputs[%0d] got a=%h b=%h op=%h rm=%h want a=%h b=%h op=%h rm=%h",
                               i, fpu_a, fpu_b, fpu_op, fpu_rmode, m_opa, m_opb, m_op, m_rmode);
         end
      end
   endtask

   task automatic test_random_ops();
      logic [31:0] rd, ex; logic ok; int n, s0;
      for (int i = 0; i < 6; i++) begin
         s0 = start_cnt;
         wb_access(1'b1, BASE + 32'h00, $urandom, rd, ex, ok);
         wb_access(1'b1, BASE + 32'h04, $urandom, rd, ex, ok);
         wb_access(1'b1, BASE + 32'h08, 32'h8000_0000 | ($urandom & 32'h11F), rd, ex, ok);
         checks++;
         if ({fpu_a, fpu_b, fpu_op, fpu_rmode} !== {m_opa, m_opb, m_op, m_rmode}) begin
            errors++; $display("FAIL op_outputs[%0d] got a=%h b=%h op=%h rm=%h", i, fpu_a, fpu_b, fpu_op, fpu_rmode);
         end
         n = $urandom_range(2, TMO + 4);
         fpu_finish(n, $urandom, 5'($urandom));
         for (int r = 3; r < 6; r++) begin
            wb_access(1'b0, BASE + 32'(r * 4), 32'h0, rd, ex, ok);
            checks++;
            if (rd !== ex) begin
               errors++; $display("FAIL op_read[%0d][%0d] n=%0d got %h want %h", i, r, n, rd, ex);
            end
         end
         checks++;
         if (irq !== (m_done & m_irq_en) || start_cnt !== s0 + 1) begin
            errors++; $display("FAIL op_irq_start[%0d] got irq=%b starts=%0d want %b and 1",
                               i, irq, start_cnt - s0, m_done & m_irq_en);
         end
         wb_access(1'b1, BASE + 32'h0C, $urandom & 32'h182, rd, ex, ok);
      end
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd, ex; logic ok; int s0;
      wb_access(1'b1, BASE + 32'h00, $urandom | 32'h1, rd, ex, ok);
      wb_access(1'b1, BASE + 32'h08, 32'h8000_011F, rd, ex, ok);
      s0 = start_cnt;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s_ack_o, s_dat_o, fpu_start, irq, fpu_a, fpu_b, fpu_op, fpu_rmode} !== 104'h0) begin
         errors++; $display("FAIL midop_reset_outputs got a=%h op=%h start=%b irq=%b want all 0",
                            fpu_a, fpu_op, fpu_start, irq);
      end
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      pulse_done(32'h1234_5678, 5'h1F);
      for (int i = 3; i < 6; i++) begin
         wb_access(1'b0, BASE + 32'(i * 4), 32'h0, rd, ex, ok);
         checks++;
         if (rd !== ex) begin
            errors++; $display("FAIL midop_read[%0d] got %h want %h", i, rd, ex);
         end
      end
      checks++;
      if (start_cnt !== s0) begin
         errors++; $display("FAIL midop_no_restart got %0d extra starts want 0", start_cnt - s0);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic_op();
      test_w1c_irq();
      test_busy_err();
      test_timeout();
      test_done_at_limit();
      test_decode();
      test_back_to_back();
      test_random_regs();
      test_random_ops();
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, errors);
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/fpu_wb_regs.md
Name: fpu_wb_regs

Overview:
- Wishbone slave register block directly downstream of the AHB-to-Wishbone bridge; consumes its strobe/write/address/data and returns ack plus read data.
- Holds the FPU operand, control and status registers and issues a one-cycle start to the FPU core.
- Captures the core's result, flags and latency, with a timeout watchdog, and drives a level interrupt.

Parameters:
- ADDR_BASE, 32'h0000_0000, base address; bits [31:8] compared against s_adr_i[31:8].
- TIMEOUT, 1024, busy cycles before an operation is aborted; legal range 2..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_stb_i  in  1  Wishbone strobe; held high until ack
- s_we_i  in  1  write enable, valid with stb
- s_adr_i  in  32  byte address, valid with stb
- s_dat_i  in  32  write data, valid with stb
- s_dat_o  out  32  read data, valid while s_ack_o=1
- s_ack_o  out  1  single-cycle access acknowledge
- fpu_start  out  1  one-cycle operation start pulse
- fpu_op  out  3  operation code (CTRL[2:0])
- fpu_rmode  out  2  rounding mode (CTRL[4:3])
- fpu_a  out  32  operand A (OPA register)
- fpu_b  out  32  operand B (OPB register)
- fpu_done  in  1  core completion pulse
- fpu_result  in  32  result, valid with fpu_done
- fpu_flags  in  5  exception flags, valid with fpu_done
- irq  out  1  interrupt, registered level

Behaviour:
- Reset values: all registers, s_ack_o, s_dat_o, fpu_start, irq and the busy counter are 0. Reset mid-operation aborts it. Start is not re-issued after reset.
- Ack: registered, s_ack_o <= s_stb_i & ~s_ack_o. Latency is one cycle from stb to ack, and ack never lasts two cycles. A held stb gets a new ack every other cycle.
- Commit: a write commits on the same edge that raises ack. Read data is registered on that edge. s_dat_o is 0 whenever ack is 0.
- Decode: hit when s_adr_i[31:8]==ADDR_BASE[31:8]; register select is s_adr_i[4:2]. A miss or an unmapped offset is still acked, reads 0, and ignores writes.
- Register map:
  - 0x00 OPA: read/write.
  - 0x04 OPB: read/write.
  - 0x08 CTRL: read/write. [2:0] op, [4:3] rmode, [8] irq_en. Bit 31 is GO: it is self-clearing and reads 0.
  - 0x0C STATUS: [0] busy (RO), [1] done (W1C), [6:2] flags (RO), [7] err (W1C), [8] timeout (W1C).
  - 0x10 RESULT: read-only.
  - 0x14 CYCLES: read-only, [15:0] latency of the last operation.
- States are IDLE and BUSY.
- IDLE→BUSY on a committed CTRL write with bit 31=1:
  - busy=1, done=0, timeout=0 and counter=0 on the commit edge.
  - fpu_start=1 for exactly the next cycle.
  - op, rmode and irq_en from the same write take effect.
- While BUSY:
  - Writes to OPA, OPB or CTRL, including GO, are dropped and set err=1.
  - STATUS W1C writes still apply.
  - The counter increments every busy cycle, saturating at 16'hFFFF.
- BUSY→IDLE on fpu_done=1:
  - RESULT<=fpu_result and flags<=fpu_flags.
  - CYCLES<=counter+1, which counts the done cycle.
  - busy=0, done=1.
- BUSY→IDLE on timeout, when counter+1==TIMEOUT without fpu_done:
  - busy=0, done=1, timeout=1.
  - RESULT and flags are unchanged; CYCLES<=TIMEOUT.
- fpu_done while IDLE, including after a timeout, is ignored.
- If fpu_done and the timeout condition occur in the same cycle, fpu_done wins.
- Simultaneous W1C of done and a new done event: done stays 1. The same rule applies to err and timeout.
- irq <= done & irq_en, registered, so it follows its inputs by one cycle.
- fpu_a, fpu_b, fpu_op and fpu_rmode are driven continuously from the registers.

Test Plan:
- Write OPA=32'h3F80_0000, OPB=32'h4000_0000, then CTRL=32'h8000_0101.
  - Expected: each ack arrives one cycle after stb; fpu_start is high exactly one cycle; fpu_op=1, fpu_a and fpu_b match the written values.
  - Model fpu_done 3 cycles after start with result 32'h4040_0000 and flags 5'h01. Expected: STATUS=32'h0000_0006, RESULT=32'h4040_0000, CYCLES=4, irq=1.
- Write 32'h0000_0002 to STATUS → done clears and irq drops one cycle later. Read STATUS → 0.
- GO while busy, then OPA write while busy → both dropped, err=1, OPA unchanged, no second fpu_start.
- Never assert fpu_done with TIMEOUT=16 → STATUS=32'h0000_0102 and CYCLES=16. A late fpu_done is then ignored and RESULT is unchanged.
- Access address ADDR_BASE+0x100 and offset 0x1C, read and write → both acked, read 0, no register changes.
- Assert rst_n low 2 cycles after GO → all outputs 0. After reset release, fpu_done is ignored and STATUS reads 0.
